// File: rtl/deser_queue_ctrl_pkg.sv
// Shared types and constants for the deserializer byte queue controller.
package deser_queue_ctrl_pkg;

  localparam int BYTE_W = 8;

  // Capture-side handshake sequencer states.
  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    ACK       = 2'd1,
    WAIT_CLR  = 2'd2
  } qctrl_state_t;

endpackage

// File: rtl/deser_queue_ctrl_if.sv
// Bundle of the deserializer handshake and the consumer pop interface.
//
// Handshake semantics:
//   Capture side: deser_ready is a level "byte complete" flag. The controller
//   takes the byte in deser_data on the edge where deser_ready is high and the
//   queue is not full, and answers with a single-cycle deser_ack. The
//   deserializer must hold deser_ready/deser_data until it sees deser_ack, then
//   drop deser_ready. A withheld ack is the back-pressure.
//   Drain side: data_valid high means data_out holds the head byte; deq_in high
//   on an edge where data_valid is high pops it. deq_in without data_valid is
//   ignored.
interface deser_queue_ctrl_if #(
  parameter int DEPTH = 8
);
  import deser_queue_ctrl_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] deser_data;
  logic              deser_ready;
  logic              deser_ack;
  logic              deq_in;
  logic [BYTE_W-1:0] data_out;
  logic              data_valid;
  logic [LW-1:0]     level_out;
  logic              full;
  logic              err_out;
  qctrl_state_t      state_dbg;

  // Queue controller side.
  modport slave (
    input  deser_data, deser_ready, deq_in,
    output deser_ack, data_out, data_valid, level_out, full, err_out, state_dbg
  );

  // Environment side: deserializer plus consumer.
  modport master (
    output deser_data, deser_ready, deq_in,
    input  deser_ack, data_out, data_valid, level_out, full, err_out, state_dbg
  );

endinterface

// File: rtl/deser_queue_ctrl_byte_fifo.sv
// Byte FIFO with occupancy counter. Callers gate push by full and pop by empty.
module deser_queue_ctrl_byte_fifo
  import deser_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clock_100,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [BYTE_W-1:0] din_i,
  output logic [BYTE_W-1:0] dout_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  // Storage is deliberately not reset; empty forces the output to zero.
  always_ff @(posedge clock_100) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Next pointer and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/deser_queue_ctrl.sv
// Sequences the deserializer ready/ack handshake and queues captured bytes.
module deser_queue_ctrl
  import deser_queue_ctrl_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CLR_TIMEOUT = 15
) (
  input  logic              clock_100,
  input  logic              reset,
  deser_queue_ctrl_if.slave bus
);

  localparam int CW = $clog2(CLR_TIMEOUT + 1);

  qctrl_state_t      state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [BYTE_W-1:0] fifo_dout;
  logic [$clog2(DEPTH):0] fifo_level;

  // Capture FSM: take a byte when there is room, pulse ack once, then wait
  // for ready to fall, flagging a stuck-high ready after CLR_TIMEOUT cycles.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        if (bus.deser_ready && !fifo_full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        cnt_d   = '0;
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!bus.deser_ready) begin
          state_d = WAIT_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(CLR_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = WAIT_DATA;
          end
        end
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  // FSM, ack, timeout counter and sticky error registers.
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_DATA;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pop = bus.deq_in && !fifo_empty;

  deser_queue_ctrl_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock_100 (clock_100),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (pop),
    .din_i     (bus.deser_data),
    .dout_o    (fifo_dout),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bus.deser_ack  = ack_q;
  assign bus.data_out   = fifo_dout;
  assign bus.data_valid = !fifo_empty;
  assign bus.level_out  = fifo_level;
  assign bus.full       = fifo_full;
  assign bus.err_out    = err_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_deser_queue_ctrl.sv
// Directed bench: serial deserializer model feeding deser_queue_ctrl.
module tb_deser_queue_ctrl;
  import deser_queue_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock_100 = 1'b0;
  logic reset     = 1'b1;
  always #5 clock_100 = ~clock_100;

  deser_queue_ctrl_if #(.DEPTH(8)) bus();

  deser_queue_ctrl #(.DEPTH(8), .CLR_TIMEOUT(15)) dut (
    .clock_100 (clock_100),
    .reset     (reset),
    .bus       (bus)
  );

  // ---------------- deserializer model ----------------
  logic       write_in = 1'b0;
  logic       data_in  = 1'b0;
  logic       stub_mode  = 1'b0;
  logic       stub_ready = 1'b0;
  logic [7:0] stub_data  = 8'h00;
  logic [7:0] m_sh;
  logic [2:0] m_cnt;
  logic       m_rdy;

  // MSB-first shift; holds READY until acked, ignoring serial input meanwhile.
  always_ff @(posedge clock_100 or posedge reset) begin
    if (reset) begin
      m_sh  <= 8'h00;
      m_cnt <= 3'd0;
      m_rdy <= 1'b0;
    end else if (m_rdy) begin
      if (bus.deser_ack) m_rdy <= 1'b0;
    end else if (write_in) begin
      m_sh  <= {m_sh[6:0], data_in};
      m_cnt <= m_cnt + 3'd1;
      if (m_cnt == 3'd7) m_rdy <= 1'b1;
    end
  end

  assign bus.deser_ready = stub_mode ? stub_ready : m_rdy;
  assign bus.deser_data  = stub_mode ? stub_data  : m_sh;

  // Ack cycles, sampled mid-cycle.
  int ack_total = 0;
  always @(negedge clock_100) if (bus.deser_ack === 1'b1) ack_total <= ack_total + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ack_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock_100);
    #1;
  endtask

  task automatic send_serial(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      data_in  = b[i];
      write_in = 1'b1;
      tick();
    end
    write_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (m_rdy && n < 40) begin
      tick();
      n++;
    end
    check("accept_in_time", {31'd0, (n < 40)}, 32'd1);
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_serial(b);
    wait_accept();
    exp_q.push_back(b);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, {24'd0, bus.data_out}, {24'd0, e});
    bus.deq_in = 1'b1;
    tick();
    bus.deq_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.deq_in = 1'b0;
    tick(); tick();
    check("rst_level", {28'd0, bus.level_out}, 32'd0);
    check("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("rst_data",  {24'd0, bus.data_out}, 32'd0);
    check("rst_ack",   {31'd0, bus.deser_ack}, 32'd0);
    check("rst_err",   {31'd0, bus.err_out}, 32'd0);
    check("rst_full",  {31'd0, bus.full}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: single byte A5
    ack_base = ack_total;
    send_byte(8'hA5);
    check("t1_ack_once", ack_total - ack_base, 32'd1);
    check("t1_valid", {31'd0, bus.data_valid}, 32'd1);
    check("t1_data",  {24'd0, bus.data_out}, 32'hA5);
    check("t1_level", {28'd0, bus.level_out}, 32'd1);
    pop_check("t1_pop");
    check("t1_empty", {28'd0, bus.level_out}, 32'd0);

    // 2: fill to full, stall the 9th byte, release with one pop
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("t2_full",  {31'd0, bus.full}, 32'd1);
    check("t2_level", {28'd0, bus.level_out}, 32'd8);
    ack_base = ack_total;
    send_serial(8'h09);
    repeat (5) tick();
    check("t2_stall_ack",   ack_total - ack_base, 32'd0);
    check("t2_stall_ready", {31'd0, bus.deser_ready}, 32'd1);
    check("t2_stall_level", {28'd0, bus.level_out}, 32'd8);
    pop_check("t2_pop_head");
    check("t2_after_pop_level", {28'd0, bus.level_out}, 32'd7);
    check("t2_after_pop_data",  {24'd0, bus.data_out}, 32'h02);
    wait_accept();
    exp_q.push_back(8'h09);
    check("t2_refill_level", {28'd0, bus.level_out}, 32'd8);
    check("t2_refill_ack",   ack_total - ack_base, 32'd1);

    // 3: drain, pop while empty, then a byte after pointer wrap
    while (exp_q.size() > 0) pop_check("t3_drain");
    bus.deq_in = 1'b1;
    tick();
    bus.deq_in = 1'b0;
    check("t3_empty_level", {28'd0, bus.level_out}, 32'd0);
    check("t3_empty_data",  {24'd0, bus.data_out}, 32'd0);
    check("t3_empty_valid", {31'd0, bus.data_valid}, 32'd0);
    send_byte(8'h3C);
    check("t3_wrap_level", {28'd0, bus.level_out}, 32'd1);
    pop_check("t3_wrap_data");

    // 4: full FIFO, pop in the cycle ready rises: push deferred one cycle
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
    ack_base = ack_total;
    send_serial(8'h19);
    pop_check("t4_pop_head");
    check("t4_level_mid", {28'd0, bus.level_out}, 32'd7);
    check("t4_no_ack",    {31'd0, bus.deser_ack}, 32'd0);
    wait_accept();
    exp_q.push_back(8'h19);
    check("t4_level_end", {28'd0, bus.level_out}, 32'd8);
    check("t4_ack_once",  ack_total - ack_base, 32'd1);
    while (exp_q.size() > 0) pop_check("t4_drain");
    check("t4_drained", {28'd0, bus.level_out}, 32'd0);

    // 5: ready stuck high 20 cycles -> sticky error after 15 WAIT_CLR cycles
    stub_mode  = 1'b1;
    stub_data  = 8'h55;
    ack_base   = ack_total;
    stub_ready = 1'b1;
    repeat (16) tick();
    check("t5_err_before", {31'd0, bus.err_out}, 32'd0);
    tick();
    check("t5_err_set", {31'd0, bus.err_out}, 32'd1);
    repeat (3) tick();
    stub_ready = 1'b0;
    repeat (3) tick();
    stub_mode = 1'b0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    check("t5_level", {28'd0, bus.level_out}, 32'd2);
    check("t5_acks",  ack_total - ack_base, 32'd2);
    send_byte(8'h66);
    check("t5_err_sticky", {31'd0, bus.err_out}, 32'd1);
    check("t5_level_after", {28'd0, bus.level_out}, 32'd3);
    pop_check("t5_head");

    // 6: reset with 3 bytes queued, mid-byte on the serial link
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("t6_err_cleared", {31'd0, bus.err_out}, 32'd0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    check("t6_level3", {28'd0, bus.level_out}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      data_in  = 1'b1;
      write_in = 1'b1;
      tick();
    end
    write_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_level", {28'd0, bus.level_out}, 32'd0);
    check("t6_rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("t6_rst_data",  {24'd0, bus.data_out}, 32'd0);
    check("t6_rst_full",  {31'd0, bus.full}, 32'd0);
    check("t6_rst_ack",   {31'd0, bus.deser_ack}, 32'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    send_byte(8'h7E);
    check("t6_level1", {28'd0, bus.level_out}, 32'd1);
    pop_check("t6_data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
